// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store memory stage: access-size encodings
// and the bus-sequencing state type.
package lsu_mem_stage_pkg;

  // funct3 access-size / sign encodings (shared by loads and stores)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobes and replicated write data on the way out,
// lane extraction and sign/zero extension of read data on the way back.
module lsu_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statements can leave a value unassigned (latch).
  always_comb begin
    byte_lane = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
    endcase
    // Halfword accesses ignore addr[0].
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    wstrb     = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    case (funct3)
      F3_B: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_lane[7]}}, byte_lane};
      end
      F3_H: begin
        wstrb     = 4'b0011 << {addr_lo[1], 1'b0};
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_lane[15]}}, half_lane};
      end
      F3_W: begin
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
      F3_BU: load_data = {24'd0, byte_lane};
      F3_HU: load_data = {16'd0, half_lane};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory pipeline stage: sequences one bus request/response per load or store,
// passes non-memory instructions straight through, and registers the WBU payload.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [XLEN-1:0] ex_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rd_value_in,
  input  logic [RD_W-1:0] rd_in,
  input  logic [3:0]      csr_wen_in,
  input  logic            R_wen_in,
  input  logic            mem_ren_in,
  input  logic            mem_wen_in,
  input  logic [2:0]      funct3_in,
  input  logic            jump_flag_in,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [XLEN-1:0] req_addr,
  output logic            req_wen,
  output logic [XLEN-1:0] req_wdata,
  output logic [3:0]      req_wstrb,
  input  logic            rsp_valid,
  input  logic [XLEN-1:0] rsp_rdata,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] MEM_Rdata,
  output logic [XLEN-1:0] Ex_result,
  output logic [XLEN-1:0] rd_value,
  output logic [RD_W-1:0] rd,
  output logic [3:0]      csr_wen,
  output logic            R_wen,
  output logic            mem_ren,
  output logic            jump_flag
);

  lsu_state_e state_q, state_d;

  // Captured copy of the in-flight memory instruction.
  logic [XLEN-1:0] pend_ex, pend_sdata, pend_rdv;
  logic [RD_W-1:0] pend_rd;
  logic [3:0]      pend_csr;
  logic [2:0]      pend_f3;
  logic            pend_rw, pend_ren, pend_wen, pend_jmp;

  logic        accept, is_mem, load_direct, load_resp;
  logic [3:0]  al_wstrb;
  logic [31:0] al_wdata, al_load;

  assign ready_out   = (state_q == IDLE) && (!valid_out || ready_in);
  assign accept      = valid_in && ready_out;
  assign is_mem      = mem_ren_in || mem_wen_in;
  assign load_direct = accept && !is_mem;
  // A response outside WAIT (e.g. from a request abandoned by reset) is dropped.
  assign load_resp   = (state_q == WAIT) && rsp_valid;

  lsu_align u_align (
    .funct3     (pend_f3),
    .addr_lo    (pend_ex[1:0]),
    .store_data (pend_sdata),
    .rdata      (rsp_rdata),
    .wstrb      (al_wstrb),
    .wdata      (al_wdata),
    .load_data  (al_load)
  );

  // Request fields come only from captured state, so they stay stable in REQ.
  assign req_addr  = {pend_ex[XLEN-1:2], 2'b00};
  assign req_wen   = pend_wen;
  assign req_wdata = pend_wen ? al_wdata : '0;
  assign req_wstrb = pend_wen ? al_wstrb : 4'b0000;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    case (state_q)
      IDLE: if (accept && is_mem) state_d = REQ;
      REQ: begin
        req_valid = 1'b1;
        if (req_ready) state_d = WAIT;
      end
      WAIT:    if (rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: these are plain control/payload registers (no RAM), so all of them are
  // cleared by reset; an uncleared value here would leak into the bus/WBU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_ex    <= '0;
      pend_sdata <= '0;
      pend_rdv   <= '0;
      pend_rd    <= '0;
      pend_csr   <= '0;
      pend_f3    <= '0;
      pend_rw    <= 1'b0;
      pend_ren   <= 1'b0;
      pend_wen   <= 1'b0;
      pend_jmp   <= 1'b0;
    end else if (accept && is_mem) begin
      pend_ex    <= ex_result;
      pend_sdata <= store_data;
      pend_rdv   <= rd_value_in;
      pend_rd    <= rd_in;
      pend_csr   <= csr_wen_in;
      pend_f3    <= funct3_in;
      pend_rw    <= R_wen_in;
      pend_ren   <= mem_ren_in;
      pend_wen   <= mem_wen_in;
      pend_jmp   <= jump_flag_in;
    end
  end

  // Output loads only happen when the slot is free or draining this edge,
  // which keeps the payload frozen while the WBU stalls.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      MEM_Rdata <= '0;
      Ex_result <= '0;
      rd_value  <= '0;
      rd        <= '0;
      csr_wen   <= '0;
      R_wen     <= 1'b0;
      mem_ren   <= 1'b0;
      jump_flag <= 1'b0;
    end else if (load_direct) begin
      valid_out <= 1'b1;
      MEM_Rdata <= '0;
      Ex_result <= ex_result;
      rd_value  <= rd_value_in;
      rd        <= rd_in;
      csr_wen   <= csr_wen_in;
      R_wen     <= R_wen_in;
      mem_ren   <= mem_ren_in;
      jump_flag <= jump_flag_in;
    end else if (load_resp) begin
      valid_out <= 1'b1;
      MEM_Rdata <= pend_ren ? al_load : '0;
      Ex_result <= pend_ex;
      rd_value  <= pend_rdv;
      rd        <= pend_rd;
      csr_wen   <= pend_csr;
      R_wen     <= pend_rw;
      mem_ren   <= pend_ren;
      jump_flag <= pend_jmp;
    end else if (ready_in) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have parameter RD_W, default 5, register index width.
REQ-003 SHALL have these ports (clock and reset first):
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- valid_in  in  1  EXU holds a valid instruction
- ready_out  out  1  stage accepts from EXU
- ex_result  in  32  ALU result or effective address
- store_data  in  32  rs2 value
- rd_value_in  in  32  link/CSR value
- rd_in  in  5  destination register
- csr_wen_in  in  4  CSR write enables
- R_wen_in  in  1  register write enable
- mem_ren_in  in  1  load
- mem_wen_in  in  1  store
- funct3_in  in  3  access size/sign
- jump_flag_in  in  1  jump
- req_valid  out  1  memory request valid
- req_ready  in  1  memory accepts request
- req_addr  out  32  word-aligned address
- req_wen  out  1  store request
- req_wdata  out  32  lane-replicated store data
- req_wstrb  out  4  byte strobes
- rsp_valid  in  1  memory response, one per request
- rsp_rdata  in  32  raw read word
- valid_out  out  1  WBU payload valid
- ready_in  in  1  WBU ready
- MEM_Rdata  out  32  aligned, extended load data
- Ex_result  out  32  registered ex_result
- rd_value  out  32  registered rd_value_in
- rd  out  5  registered rd_in
- csr_wen  out  4  registered csr_wen_in
- R_wen  out  1  registered R_wen_in
- mem_ren  out  1  registered mem_ren_in
- jump_flag  out  1  registered jump_flag_in

Function
REQ-004 SHALL accept an instruction when valid_in & ready_out; ready_out = (state==IDLE) & (!valid_out | ready_in).
REQ-005 SHALL use FSM states IDLE, REQ, WAIT: IDLE->REQ on accept with mem_ren_in|mem_wen_in; REQ->WAIT on req_valid & req_ready; WAIT->IDLE on rsp_valid.
REQ-006 SHALL, for a non-memory accept, load the output register and assert valid_out on the next edge (1-cycle latency); no bus activity.
REQ-007 SHALL assert req_valid only in REQ, holding req_addr/req_wen/req_wdata/req_wstrb stable until req_ready.
REQ-008 SHALL drive req_addr = {ex_result[31:2],2'b00}.
REQ-009 SHALL, for stores, set wstrb: SB 4'b0001<<a[1:0], SH 4'b0011<<{a[1],1'b0}, SW 4'b1111; wdata replicates byte/half across lanes; addr[0] is ignored for halfwords.
REQ-010 SHALL, on rsp_valid in WAIT, extract the load lane by addr[1:0] and extend: LB 000 sign, LH 001 sign, LW 010, LBU 100 zero, LHU 101 zero; stores put 0 on MEM_Rdata.
REQ-011 SHALL assert valid_out on the edge after rsp_valid in WAIT; 1-cycle request acceptance gives 3-cycle accept-to-valid_out latency minimum.
REQ-012 SHALL hold valid_out and all payload outputs stable while valid_out & !ready_in, and clear valid_out on valid_out & ready_in unless a new result loads the same edge.
REQ-013 SHALL allow back-to-back non-memory instructions at one per cycle when ready_in=1.
REQ-014 SHALL ignore rsp_valid outside WAIT.
REQ-015 SHALL pass payload fields unmodified from accept to output.

Reset
REQ-016 SHALL on reset force state IDLE, valid_out=0, req_valid=0, and all registered outputs to 0, immediately and independent of clock.
REQ-017 SHALL after reset release present ready_out=1; a request in flight at reset is abandoned and its late rsp_valid ignored.

Structure
REQ-018 SHALL place funct3 encodings and the state enum in the shared package.
REQ-019 SHALL implement lane extract/extend and strobe/wdata generation in one combinational sub-module, lsu_align.

Verification
REQ-020 ALU op ex_result=0x1234, ready_in=1 -> valid_out next cycle, Ex_result=0x1234, no req_valid.
REQ-021 LB addr 0x1003, rsp_rdata=0x80FF_FF12 -> req_addr=0x1000, MEM_Rdata=0xFFFFFF80; LBU -> 0x00000080.
REQ-022 SH addr 0x2002, store_data=0xABCD -> req_wstrb=4'b1100, req_wdata=0xABCDABCD, valid_out after rsp_valid.
REQ-023 req_ready low 3 cycles -> req fields stable, ready_out=0 throughout.
REQ-024 ready_in low 4 cycles with valid_out=1 -> outputs stable, ready_out=0, no new accept.
REQ-025 reset asserted in WAIT, then late rsp_valid -> valid_out stays 0, state IDLE, ready_out=1.
